// File: rtl/spsram_arb.sv
// Two-port round-robin arbiter/sequencer in front of a single-port SRAM.
// Define SPSRAM_ARB_RDATA_REG_EN to register the read-return strobe and data (+1 cycle latency).
module spsram_arb #(
    parameter int DW = 32,
    parameter int AW = 16
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_req0,
    input  logic          i_wr0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_ack0,
    output logic          o_rvalid0,
    output logic [DW-1:0] o_rdata0,
    input  logic          i_req1,
    input  logic          i_wr1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack1,
    output logic          o_rvalid1,
    output logic [DW-1:0] o_rdata1,
    output logic          o_sram_csn,
    output logic          o_sram_wr,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_wdata,
    input  logic [DW-1:0] i_sram_rdata
);

    logic          last_q, last_d;
    logic          csn_q, csn_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s1_own_q, s1_own_d;
    logic          s2_vld_q, s2_vld_d;
    logic          s2_own_q, s2_own_d;
    logic          ack0, ack1;
    logic          acc0, acc1;
    logic          ret0, ret1;

    // Grant is forced low during reset so nothing is accepted while reset is asserted.
    always_comb begin
        ack0 = 1'b0;
        ack1 = 1'b0;
        if (i_rstn) begin
            if (i_req0 && i_req1) begin
                ack0 = last_q;
                ack1 = ~last_q;
            end else begin
                ack0 = i_req0;
                ack1 = i_req1;
            end
        end
    end

    assign acc0   = i_req0 & ack0;
    assign acc1   = i_req1 & ack1;
    assign o_ack0 = ack0;
    assign o_ack1 = ack1;

    always_comb begin
        last_d   = last_q;
        csn_d    = 1'b1;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        s1_vld_d = 1'b0;
        s1_own_d = s1_own_q;
        if (acc0) begin
            last_d   = 1'b0;
            csn_d    = 1'b0;
            wr_d     = i_wr0;
            addr_d   = i_addr0;
            wdata_d  = i_wdata0;
            s1_vld_d = ~i_wr0;
            s1_own_d = 1'b0;
        end else if (acc1) begin
            last_d   = 1'b1;
            csn_d    = 1'b0;
            wr_d     = i_wr1;
            addr_d   = i_addr1;
            wdata_d  = i_wdata1;
            s1_vld_d = ~i_wr1;
            s1_own_d = 1'b1;
        end
        s2_vld_d = s1_vld_q;
        s2_own_d = s1_own_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            last_q   <= 1'b1;
            csn_q    <= 1'b1;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            s1_vld_q <= 1'b0;
            s1_own_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_own_q <= 1'b0;
        end else begin
            last_q   <= last_d;
            csn_q    <= csn_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            s1_vld_q <= s1_vld_d;
            s1_own_q <= s1_own_d;
            s2_vld_q <= s2_vld_d;
            s2_own_q <= s2_own_d;
        end
    end

    assign o_sram_csn   = csn_q;
    assign o_sram_wr    = wr_q;
    assign o_sram_addr  = addr_q;
    assign o_sram_wdata = wdata_q;

    // Stage 2 lines up with the cycle in which the SRAM drives its read data.
    assign ret0 = s2_vld_q & ~s2_own_q;
    assign ret1 = s2_vld_q & s2_own_q;

`ifdef SPSRAM_ARB_RDATA_REG_EN
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    always_comb begin
        rvalid0_d = ret0;
        rvalid1_d = ret1;
        rdata0_d  = ret0 ? i_sram_rdata : '0;
        rdata1_d  = ret1 ? i_sram_rdata : '0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign o_rvalid0 = rvalid0_q;
    assign o_rvalid1 = rvalid1_q;
    assign o_rdata0  = rdata0_q;
    assign o_rdata1  = rdata1_q;
`else
    assign o_rvalid0 = ret0;
    assign o_rvalid1 = ret1;
    assign o_rdata0  = ret0 ? i_sram_rdata : '0;
    assign o_rdata1  = ret1 ? i_sram_rdata : '0;
`endif

endmodule

// File: tb/tb_spsram_arb.sv
// Randomized self-checking bench for spsram_arb against a transaction-level model.
// Honours SPSRAM_ARB_RDATA_REG_EN for the expected read latency.
module tb_spsram_arb;

`ifdef SPSRAM_ARB_RDATA_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } readT;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req0, wr0, req1, wr1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        sramCsn, sramWr;
    logic [15:0] sramAddr;
    logic [31:0] sramWdata;
    logic [31:0] sramRdata;

    logic [31:0] sramMem [65536];
    logic [31:0] refMem [65536];
    readT        pend[$];
    bit          lastG;
    bit          expCsn, expWr;
    logic [15:0] expAddr;
    logic [31:0] expWdata;
    bit          accPrev0, accPrev1;
    int          cyc;
    int          total;
    int          bad;

    spsram_arb #(.DW(32), .AW(16)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_req0(req0), .i_wr0(wr0), .i_addr0(addr0), .i_wdata0(wdata0),
        .o_ack0(ack0), .o_rvalid0(rvalid0), .o_rdata0(rdata0),
        .i_req1(req1), .i_wr1(wr1), .i_addr1(addr1), .i_wdata1(wdata1),
        .o_ack1(ack1), .o_rvalid1(rvalid1), .o_rdata1(rdata1),
        .o_sram_csn(sramCsn), .o_sram_wr(sramWr), .o_sram_addr(sramAddr),
        .o_sram_wdata(sramWdata), .i_sram_rdata(sramRdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port SRAM: data valid for one cycle after a read is sampled, Z otherwise.
    initial sramRdata = 'z;
    always @(posedge clk) begin
        sramRdata <= 'z;
        if (!sramCsn) begin
            if (sramWr) sramMem[sramAddr] <= sramWdata;
            else        sramRdata <= sramMem[sramAddr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: compare everything at the falling edge, then advance the model on the rising edge.
    task automatic runCycle();
        bit          expAck0, expAck1, expV0, expV1, port, w;
        logic [31:0] expD0, expD1, d;
        logic [15:0] a;
        readT        r;
        @(negedge clk);
        if (!rstn) begin
            pend.delete();
            lastG    = 1'b1;
            expCsn   = 1'b1;
            expWr    = 1'b0;
            expAddr  = '0;
            expWdata = '0;
        end
        expAck0 = 1'b0;
        expAck1 = 1'b0;
        if (rstn) begin
            if (req0 && req1) begin
                expAck0 = (lastG == 1'b1);
                expAck1 = (lastG == 1'b0);
            end else begin
                expAck0 = req0;
                expAck1 = req1;
            end
        end
        expV0 = 1'b0; expV1 = 1'b0; expD0 = '0; expD1 = '0;
        foreach (pend[i]) begin
            if (pend[i].due == cyc) begin
                if (pend[i].port) begin expV1 = 1'b1; expD1 = pend[i].data; end
                else              begin expV0 = 1'b1; expD0 = pend[i].data; end
            end
        end
        checkOutput("ack0", 32'(ack0), 32'(expAck0));
        checkOutput("ack1", 32'(ack1), 32'(expAck1));
        checkOutput("csn", 32'(sramCsn), 32'(expCsn));
        checkOutput("wr", 32'(sramWr), 32'(expWr));
        checkOutput("addr", 32'(sramAddr), 32'(expAddr));
        checkOutput("wdata", sramWdata, expWdata);
        checkOutput("rvalid0", 32'(rvalid0), 32'(expV0));
        checkOutput("rvalid1", 32'(rvalid1), 32'(expV1));
        checkOutput("rdata0", rdata0, expD0);
        checkOutput("rdata1", rdata1, expD1);
        accPrev0 = 1'b0;
        accPrev1 = 1'b0;
        @(posedge clk);
        cyc++;
        if (rstn) begin
            accPrev0 = req0 & expAck0;
            accPrev1 = req1 & expAck1;
            expCsn   = !(accPrev0 || accPrev1);
            if (accPrev0 || accPrev1) begin
                port = accPrev1;
                w    = port ? wr1 : wr0;
                a    = port ? addr1 : addr0;
                d    = port ? wdata1 : wdata0;
                lastG    = port;
                expWr    = w;
                expAddr  = a;
                expWdata = d;
                if (w) refMem[a] = d;
                else begin
                    r.due  = cyc + LAT;
                    r.port = port;
                    r.data = refMem[a];
                    pend.push_back(r);
                end
            end
            while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
        end
        #1;
    endtask

    task automatic applyStimulus(input bit r0, input bit w0, input logic [15:0] a0, input logic [31:0] d0,
                                 input bit r1, input bit w1, input logic [15:0] a1, input logic [31:0] d1);
        req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
        runCycle();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 16'h0, 32'h0, 0, 0, 16'h0, 32'h0);
    endtask

    function automatic logic [15:0] pickAddr();
        if ($urandom_range(0, 4) == 0) return 16'hFFFF;
        return 16'($urandom_range(0, 7));
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lastG = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            sramMem[i] = $urandom;
            refMem[i]  = sramMem[i];
        end
        rstn = 1'b1;
        req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0003; wdata0 = 32'h0;
        req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0004; wdata1 = 32'h0;
        #2 rstn = 1'b0;

        // Reset held with both requesting, then release: port 0 wins first
        for (int i = 0; i < 3; i++) runCycle();
        rstn = 1'b1;
        applyStimulus(1, 0, 16'h0003, 32'h0, 1, 0, 16'h0004, 32'h0);
        applyStimulus(0, 0, 16'h0, 32'h0, 1, 0, 16'h0004, 32'h0);
        idleCycles(3);

        $display("[TB] single write then read");
        applyStimulus(1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 16'h0, 32'h0);
        applyStimulus(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
        idleCycles(3);

        $display("[TB] contention");
        applyStimulus(1, 1, 16'h0001, 32'h11, 0, 0, 16'h0, 32'h0);
        applyStimulus(0, 0, 16'h0, 32'h0, 1, 1, 16'h0002, 32'h22);
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 16'h0001, 32'h0, 1, 0, 16'h0002, 32'h0);
        idleCycles(3);

        $display("[TB] write/read hazard at top address");
        applyStimulus(0, 0, 16'h0, 32'h0, 1, 1, 16'hFFFF, 32'h5A5A5A5A);
        applyStimulus(1, 0, 16'hFFFF, 32'h0, 0, 0, 16'h0, 32'h0);
        idleCycles(3);

        $display("[TB] reset mid-flight");
        applyStimulus(1, 0, 16'h0010, 32'h0, 0, 0, 16'h0, 32'h0);
        rstn = 1'b0;
        idleCycles(2);
        rstn = 1'b1;
        idleCycles(4);

        $display("[TB] idle with floating SRAM output");
        idleCycles(10);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            if (!(req0 && !accPrev0 && $urandom_range(0, 3) != 0)) begin
                req0 = ($urandom_range(0, 2) != 0); wr0 = 1'($urandom_range(0, 1));
                addr0 = pickAddr(); wdata0 = $urandom;
            end
            if (!(req1 && !accPrev1 && $urandom_range(0, 3) != 0)) begin
                req1 = ($urandom_range(0, 2) != 0); wr1 = 1'($urandom_range(0, 1));
                addr1 = pickAddr(); wdata1 = $urandom;
            end
            runCycle();
        end
        idleCycles(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
